// File: rtl/sha1_round_ctrl.sv
// rtl/sha1_round_ctrl.sv - SHA-1 block sequencing controller (optional SHA1_CTRL_BLK_CNT_EN block counter)
module sha1_round_ctrl #(
    parameter int NUM_ROUNDS = 80
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       blk_valid,
    input  logic       blk_first,
    input  logic       abort,
    output logic       blk_ready,
    output logic       w_init,
    output logic       w_next,
    output logic       digest_init,
    output logic       ab_init,
    output logic       round_we,
    output logic       digest_update,
    output logic [6:0] round,
    output logic [1:0] f_sel,
    output logic       busy,
    output logic       digest_valid
`ifdef SHA1_CTRL_BLK_CNT_EN
    ,
    output logic [31:0] blk_cnt
`endif
);

    localparam int GRP = NUM_ROUNDS / 4;
    localparam logic [6:0] LAST_ROUND = 7'(NUM_ROUNDS - 1);
    localparam logic [6:0] GRP1 = 7'(GRP);
    localparam logic [6:0] GRP2 = 7'(2 * GRP);
    localparam logic [6:0] GRP3 = 7'(3 * GRP);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ROUNDS,
        DONE
    } state_t;

    state_t state, state_nxt;
    logic   msg_open;
    logic   accept;
    logic   first_eff;

    assign accept    = (state == IDLE) && blk_valid && !abort;
    assign first_eff = blk_first || !msg_open;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are gated by abort so an aborted block never reaches the digest.
    always_comb begin
        state_nxt     = state;
        blk_ready     = (state == IDLE);
        busy          = (state != IDLE);
        w_init        = 1'b0;
        w_next        = 1'b0;
        digest_init   = 1'b0;
        ab_init       = 1'b0;
        round_we      = 1'b0;
        digest_update = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    w_init      = 1'b1;
                    digest_init = first_eff;
                    state_nxt   = INIT;
                end
            end
            INIT: begin
                ab_init   = !abort;
                state_nxt = ROUNDS;
            end
            ROUNDS: begin
                round_we = !abort;
                w_next   = !abort;
                if (round == LAST_ROUND) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                digest_update = !abort;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        f_sel = 2'd0;
        if (state == ROUNDS) begin
            if (round >= GRP3) begin
                f_sel = 2'd3;
            end else if (round >= GRP2) begin
                f_sel = 2'd2;
            end else if (round >= GRP1) begin
                f_sel = 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round        <= 7'd0;
            digest_valid <= 1'b0;
            msg_open     <= 1'b0;
        end else if (abort) begin
            round        <= 7'd0;
            digest_valid <= 1'b0;
            msg_open     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        digest_valid <= 1'b0;
                        msg_open     <= 1'b1;
                    end
                end
                INIT:   round <= 7'd0;
                ROUNDS: begin
                    if (round != LAST_ROUND) begin
                        round <= round + 7'd1;
                    end
                end
                DONE:   digest_valid <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SHA1_CTRL_BLK_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt <= 32'd0;
        end else if (abort) begin
            blk_cnt <= 32'd0;
        end else if (accept && first_eff) begin
            blk_cnt <= 32'd0;
        end else if (state == DONE) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule
